// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
package dsp_pkg;

  // OPMODE encodings: X mux = M, Z mux = 0 (load) or P (accumulate).
  localparam logic [7:0] OPM_MUL_LOAD = 8'h01;
  localparam logic [7:0] OPM_MUL_ACC  = 8'h09;
  localparam logic [7:0] OPM_IDLE     = 8'h00;

  // A1/B1 register + MREG + PREG for the targeted slice configuration.
  localparam int DSP48A1_PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/shift_pipe.sv
// Asynchronously reset delay line; taps[i*WIDTH +: WIDTH] is din delayed by i+1 cycles.
module shift_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] taps
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

  // Shift din through DEPTH stages; reset empties the line immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign taps = stage_reg;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice as a dot-product engine: issues operand beats, aligns
// OPMODE/CEP with the slice pipeline and captures the accumulated P.
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int A_WIDTH      = 18,
  parameter int B_WIDTH      = 18,
  parameter int P_WIDTH      = 48,
  parameter int OPMODE_WIDTH = 8,
  parameter int CNT_WIDTH    = 8,
  parameter int PIPE_LAT     = DSP48A1_PIPE_LAT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_WIDTH-1:0]      in_a,
  input  logic [B_WIDTH-1:0]      in_b,
  input  logic                    in_last,
  output logic [A_WIDTH-1:0]      dsp_a,
  output logic [B_WIDTH-1:0]      dsp_b,
  output logic                    dsp_cea,
  output logic                    dsp_ceb,
  output logic                    dsp_cem,
  output logic                    dsp_cep,
  output logic [OPMODE_WIDTH-1:0] dsp_opmode,
  input  logic [P_WIDTH-1:0]      dsp_p,
  output logic [P_WIDTH-1:0]      res_p,
  output logic [CNT_WIDTH-1:0]    res_count,
  output logic                    res_ovf,
  output logic                    res_valid,
  input  logic                    res_ready
);

  localparam int PIPE_DEPTH = PIPE_LAT - 1;

  seq_state_t state_reg, state_next;
  logic [CNT_WIDTH-1:0]    drain_cnt_reg;
  logic                    fire;
  logic                    first;
  logic                    capture;
  logic [2*PIPE_DEPTH-1:0] pipe_taps;
  logic [1:0]              tap_op;
  logic                    pipe_unused;

  assign fire    = in_valid & in_ready;
  assign first   = fire & (state_reg == IDLE);
  assign capture = (state_reg == DRAIN) && (drain_cnt_reg == CNT_WIDTH'(PIPE_LAT));

  // Operands go straight to the slice; its A1/B1 registers do the capture.
  assign dsp_a   = in_a;
  assign dsp_b   = in_b;
  assign dsp_cea = fire;
  assign dsp_ceb = fire;

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and input-side ready.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? DRAIN : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (capture) state_next = DONE;
      end
      DONE: begin
        if (res_valid && res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts cycles since the last beat fired; reads 1 in the cycle after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drain_cnt_reg <= '0;
    end else if (fire && in_last) begin
      drain_cnt_reg <= CNT_WIDTH'(1);
    end else if (state_reg == DRAIN && !capture) begin
      drain_cnt_reg <= drain_cnt_reg + CNT_WIDTH'(1);
    end
  end

  // Beat counter: restarts on the first beat, saturates and flags overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else if (fire) begin
      if (state_reg == IDLE) begin
        res_count <= CNT_WIDTH'(1);
        res_ovf   <= 1'b0;
      end else if (res_count == '1) begin
        res_ovf <= 1'b1;
      end else begin
        res_count <= res_count + CNT_WIDTH'(1);
      end
    end
  end

  // Result capture once P holds the last product, then the result handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_p     <= '0;
      res_valid <= 1'b0;
    end else if (capture) begin
      res_p     <= dsp_p;
      res_valid <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // M register is always enabled once out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) dsp_cem <= 1'b0;
    else     dsp_cem <= 1'b1;
  end

  // Delay line carrying {fire, first} to line up OPMODE and CEP with the slice.
  shift_pipe #(
    .DEPTH(PIPE_DEPTH),
    .WIDTH(2)
  ) u_pipe (
    .CLK (CLK),
    .RST (RST),
    .din ({fire, first}),
    .taps(pipe_taps)
  );

  assign tap_op  = pipe_taps[1:0];
  assign dsp_cep = pipe_taps[(PIPE_DEPTH-1)*2 + 1];
  assign dsp_opmode = !tap_op[1] ? OPMODE_WIDTH'(OPM_IDLE)
                    : tap_op[0]  ? OPMODE_WIDTH'(OPM_MUL_LOAD)
                                 : OPMODE_WIDTH'(OPM_MUL_ACC);

  // The first flag at the later taps travels along but is not needed there.
  assign pipe_unused = &{1'b0, pipe_taps};

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer with a behavioural DSP48A1 slice and a
// dot-product reference computed directly from the operand vectors.
module tb_dsp_mac_sequencer;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam int OW = 8;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic          in_last = 1'b0;
  logic [AW-1:0] dsp_a;
  logic [BW-1:0] dsp_b;
  logic          dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
  logic [OW-1:0] dsp_opmode;
  logic [PW-1:0] dsp_p;
  logic [PW-1:0] res_p;
  logic [CW-1:0] res_count;
  logic          res_ovf;
  logic          res_valid;
  logic          res_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cep_cnt = 0;

  logic [AW-1:0] va [300];
  logic [BW-1:0] vb [300];

  dsp_mac_sequencer dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
    .res_p(res_p), .res_count(res_count), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (dsp_cep === 1'b1) cep_cnt <= cep_cnt + 1;

  // Behavioural DSP48A1 slice: A1/B1, M, OPMODE and P registers (no reset, so
  // stale P survives a sequencer reset).
  logic signed [AW-1:0] a1_m = '0;
  logic signed [BW-1:0] b1_m = '0;
  logic signed [PW-1:0] m_m = '0;
  logic signed [PW-1:0] p_m = '0;
  logic [OW-1:0]        opm_m = '0;
  always @(posedge CLK) begin
    if (dsp_cea) a1_m <= dsp_a;
    if (dsp_ceb) b1_m <= dsp_b;
    if (dsp_cem) m_m <= a1_m * b1_m;
    opm_m <= dsp_opmode;
    if (dsp_cep) p_m <= ((opm_m[3:2] == 2'b10) ? p_m : '0) + ((opm_m[1:0] == 2'b01) ? m_m : '0);
  end
  assign dsp_p = p_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_dot(input int n);
    longint acc = 0;
    for (int k = 0; k < n; k++) acc += longint'($signed(va[k])) * longint'($signed(vb[k]));
    return acc[PW-1:0];
  endfunction

  // Issue n beats from va/vb with gap idle cycles after each; called at a negedge.
  task automatic send_vec(input int n, input int gap, output int t_last);
    t_last = 0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_a = va[k]; in_b = vb[k]; in_last = (k == n - 1);
      #1;
      if (k == 0) begin
        check("in_ready_first_beat", 64'(in_ready), 64'd1);
        check("dsp_cea_fire", 64'(dsp_cea), 64'd1);
        check("dsp_a_pass", 64'(dsp_a), 64'(va[0]));
        check("dsp_b_pass", 64'(dsp_b), 64'(vb[0]));
      end
      t_last = cyc;
      @(negedge CLK);
      check("opmode_beat", 64'(dsp_opmode), (k == 0) ? 64'h01 : 64'h09);
      in_valid = 1'b0; in_last = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        if (g == 0) check("opmode_bubble", 64'(dsp_opmode), 64'h00);
      end
    end
  endtask

  // Wait for the result, check it, hold it for `hold` cycles, then handshake.
  task automatic collect(input int n, input int t_last, input int hold, input int cep_base);
    int waited = 0;
    logic [PW-1:0] exp_p;
    exp_p = ref_dot(n);
    while (res_valid !== 1'b1 && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
    check("res_valid_cycle", 64'(cyc), 64'(t_last + 4));
    check("res_p", 64'(res_p), 64'(exp_p));
    check("res_count", 64'(res_count), 64'((n > 255) ? 255 : n));
    check("res_ovf", 64'(res_ovf), 64'(n > 255));
    check("cep_pulses", 64'(cep_cnt - cep_base), 64'(n));
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check("hold_res_p", 64'(res_p), 64'(exp_p));
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("res_valid_cleared", 64'(res_valid), 64'd0);
  endtask

  task automatic run(input int n, input int gap, input int hold, input string name);
    int t_last;
    int base;
    base = cep_cnt;
    send_vec(n, gap, t_last);
    collect(n, t_last, hold, base);
    $display("vector %s: n=%0d gap=%0d hold=%0d res_p=%0h res_count=%0d", name, n, gap, hold, res_p, res_count);
  endtask

  task automatic load_1234(input int n);
    for (int k = 0; k < n; k++) begin
      va[k] = AW'(k + 1);
      vb[k] = BW'(k + 5);
    end
  endtask

  initial begin
    // Reset state
    @(negedge CLK);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_cem", 64'(dsp_cem), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'd0);
    check("rst_cep", 64'(dsp_cep), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    check("rst_res_count", 64'(res_count), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("cem_after_rst", 64'(dsp_cem), 64'd1);
    $display("reset: res_valid=%0b cem=%0b in_ready=%0b", res_valid, dsp_cem, in_ready);

    // Back-to-back, bubbles, single negative beat, most-negative operands
    load_1234(4);
    run(4, 0, 0, "b2b_1234");
    run(4, 2, 0, "bubble_1234");
    va[0] = AW'(-3); vb[0] = BW'(7);
    run(1, 0, 0, "single_neg");
    va[0] = 18'h20000; vb[0] = 18'h20000; va[1] = 18'h20000; vb[1] = 18'h20000;
    run(2, 0, 0, "min_neg");

    // Result held under backpressure, then next vector right after handshake
    load_1234(4);
    run(4, 0, 5, "hold_1234");
    run(4, 1, 0, "after_hold");

    // Reset during beat 3
    load_1234(4);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = va[k]; in_b = vb[k]; in_last = 1'b0;
      @(negedge CLK);
    end
    in_a = va[2]; in_b = vb[2];
    #2 RST = 1'b1;
    #1;
    check("midrst_opmode", 64'(dsp_opmode), 64'd0);
    check("midrst_cep", 64'(dsp_cep), 64'd0);
    check("midrst_cem", 64'(dsp_cem), 64'd0);
    check("midrst_res_p", 64'(res_p), 64'd0);
    check("midrst_res_count", 64'(res_count), 64'd0);
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    $display("mid-vector reset: opmode=%0h cep=%0b res_p=%0h", dsp_opmode, dsp_cep, res_p);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    va[0] = AW'(2); vb[0] = BW'(3); va[1] = AW'(2); vb[1] = BW'(3);
    run(2, 0, 0, "after_rst_2233");

    // Random vectors
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 9));
      for (int k = 0; k < n; k++) begin
        va[k] = AW'($urandom());
        vb[k] = BW'($urandom());
      end
      run(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
    end

    // Beat count saturation
    for (int k = 0; k < 260; k++) begin
      va[k] = AW'(int'($urandom_range(0, 63)) - 32);
      vb[k] = BW'(int'($urandom_range(0, 63)) - 32);
    end
    run(260, 0, 0, "saturate");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
